mist_video_timing: RTL and testbench

//  Front-end timing stage for the MiST video pipeline, placed between core video output and scandoubler/OSD.

---
 rtl/mist_video_pkg.sv | 30 +++
 rtl/mist_sync_polarity.sv | 54 +++++
 rtl/mist_video_timing.sv | 144 ++++++++++++++
 tb/tb_mist_video_timing.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mist_video_pkg.sv
// Shared helpers for the MiST video timing front end.
// Colour widening, saturating counter step and csync combine modes.
package mist_video_pkg;

  localparam int MAX_DEPTH = 16;
  localparam bit CSYNC_XOR = 1'b0;
  localparam bit CSYNC_AND = 1'b1;

  typedef logic [MAX_DEPTH-1:0] wide_t;

  // Result sits in the low od bits: {v, v, ...} cut to od MSBs.
  function automatic wide_t expand(input wide_t v, input int cd,
                                   input int od);
    wide_t r;
    r = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (i < od) begin
        r[4'(od - 1 - i)] = v[4'(cd - 1 - (i % cd))];
      end
    end
    return r;
  endfunction

  function automatic wide_t sat_inc(input wide_t v, input int w);
    wide_t top;
    top = wide_t'((64'd1 << w) - 64'd1);
    return (v == top) ? v : v + wide_t'(1);
  endfunction

endpackage

// File: rtl/mist_sync_polarity.sv
// Sync polarity detector: compares time spent high vs low between
// rising edges of a raw sync and reports the shorter level as active.
module mist_sync_polarity
  import mist_video_pkg::*;
#(
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 cnt_en,
  input  logic                 sync,
  output logic                 valid,
  output logic                 pol,
  output logic                 dec,
  output logic [CNT_WIDTH-1:0] period
);

  logic                 sync_q;
  logic                 rise;
  logic [CNT_WIDTH-1:0] hi_cnt;
  logic [CNT_WIDTH-1:0] lo_cnt;
  logic [CNT_WIDTH:0]   sum;

  assign rise   = sync & ~sync_q;
  assign dec    = rise & valid;
  assign sum    = {1'b0, hi_cnt} + {1'b0, lo_cnt};
  assign period = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];

  // sync_q follows sync in reset so a level held through reset
  // is not mistaken for an edge.
  always_ff @(posedge clk_sys) begin
    sync_q <= sync;
    if (reset) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
      valid  <= 1'b0;
      pol    <= 1'b0;
    end else if (rise) begin
      valid <= 1'b1;
      if (valid && hi_cnt != lo_cnt) begin
        pol <= hi_cnt < lo_cnt;
      end
      hi_cnt <= CNT_WIDTH'(cnt_en);
      lo_cnt <= '0;
    end else if (cnt_en) begin
      if (sync) begin
        hi_cnt <= CNT_WIDTH'(sat_inc(wide_t'(hi_cnt), CNT_WIDTH));
      end else begin
        lo_cnt <= CNT_WIDTH'(sat_inc(wide_t'(lo_cnt), CNT_WIDTH));
      end
    end
  end

endmodule

// File: rtl/mist_video_timing.sv
// MiST video front end: pixel ce, sync polarity normalise, colour widen.
// Define VID_MEASURE_EN to build h_total/v_total/stable measurement.
module mist_video_timing
  import mist_video_pkg::*;
#(
  parameter int COLOR_DEPTH = 6,
  parameter int OUT_DEPTH   = 8,
  parameter int DIV_WIDTH   = 3,
  parameter int HCNT_WIDTH  = 12,
  parameter int VCNT_WIDTH  = 11,
  parameter int SYNC_AND    = 0
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [DIV_WIDTH-1:0]   ce_div,
  input  logic                   csync_en,
  input  logic [COLOR_DEPTH-1:0] R,
  input  logic [COLOR_DEPTH-1:0] G,
  input  logic [COLOR_DEPTH-1:0] B,
  input  logic                   HSync,
  input  logic                   VSync,
  output logic [OUT_DEPTH-1:0]   R_out,
  output logic [OUT_DEPTH-1:0]   G_out,
  output logic [OUT_DEPTH-1:0]   B_out,
  output logic                   HS_out,
  output logic                   VS_out,
  output logic                   ce_pix,
  output logic                   hs_pol,
  output logic                   vs_pol,
  output logic                   stable,
  output logic [HCNT_WIDTH-1:0]  h_total,
  output logic [VCNT_WIDTH-1:0]  v_total
);

  localparam bit AND_MODE = (SYNC_AND != 0) ? CSYNC_AND : CSYNC_XOR;

  logic                   hs_a, vs_a;
  logic                   hs1, vs1;
  logic                   hs_lead, tick, csync_n;
  logic [COLOR_DEPTH-1:0] r1, g1, b1;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic                   h_valid, v_valid, h_dec, v_dec;
  logic [HCNT_WIDTH-1:0]  h_period;
  logic [VCNT_WIDTH-1:0]  v_period;

  assign hs_a    = hs_pol ? HSync : ~HSync;
  assign vs_a    = vs_pol ? VSync : ~VSync;
  assign hs_lead = hs_a & ~hs1;
  assign tick    = div_cnt >= ce_div;
  assign csync_n = (AND_MODE == CSYNC_AND) ? ~(hs1 | vs1) : ~(hs1 ^ vs1);

  mist_sync_polarity #(.CNT_WIDTH(HCNT_WIDTH)) u_hpol (
    .clk_sys (clk_sys),
    .reset   (reset),
    .cnt_en  (1'b1),
    .sync    (HSync),
    .valid   (h_valid),
    .pol     (hs_pol),
    .dec     (h_dec),
    .period  (h_period)
  );

  mist_sync_polarity #(.CNT_WIDTH(VCNT_WIDTH)) u_vpol (
    .clk_sys (clk_sys),
    .reset   (reset),
    .cnt_en  (hs_lead),
    .sync    (VSync),
    .valid   (v_valid),
    .pol     (vs_pol),
    .dec     (v_dec),
    .period  (v_period)
  );

  // Line start re-phases the divider ahead of the normal wrap.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r1      <= '0;
      g1      <= '0;
      b1      <= '0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      div_cnt <= '0;
      ce_pix  <= 1'b0;
    end else begin
      r1      <= R;
      g1      <= G;
      b1      <= B;
      hs1     <= hs_a;
      vs1     <= vs_a;
      ce_pix  <= tick;
      div_cnt <= (hs_lead | tick) ? '0 : div_cnt + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      R_out  <= '0;
      G_out  <= '0;
      B_out  <= '0;
      HS_out <= 1'b1;
      VS_out <= 1'b1;
    end else if (ce_pix) begin
      R_out  <= OUT_DEPTH'(expand(wide_t'(r1), COLOR_DEPTH, OUT_DEPTH));
      G_out  <= OUT_DEPTH'(expand(wide_t'(g1), COLOR_DEPTH, OUT_DEPTH));
      B_out  <= OUT_DEPTH'(expand(wide_t'(b1), COLOR_DEPTH, OUT_DEPTH));
      HS_out <= csync_en ? csync_n : ~hs1;
      VS_out <= csync_en ? 1'b1 : ~vs1;
    end
  end

  logic unused_valid;
  assign unused_valid = h_valid ^ v_valid;

`ifdef VID_MEASURE_EN
  logic h_eq, v_eq;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      h_total <= '0;
      v_total <= '0;
      h_eq    <= 1'b0;
      v_eq    <= 1'b0;
    end else begin
      if (h_dec) begin
        h_total <= h_period;
        h_eq    <= h_period == h_total;
      end
      if (v_dec) begin
        v_total <= v_period;
        v_eq    <= v_period == v_total;
      end
    end
  end

  assign stable = h_eq & v_eq;
`else
  logic unused_meas;
  assign unused_meas = ^{h_period, v_period, h_dec, v_dec};
  assign stable  = 1'b0;
  assign h_total = '0;
  assign v_total = '0;
`endif

endmodule

// File: tb/tb_mist_video_timing.sv
// Bench for mist_video_timing: history-based reference model,
// per-cycle expected outputs queued and checked by a monitor.
module tb_mist_video_timing;

  localparam int CD = 6;
  localparam int OD = 8;
  localparam int DW = 3;
  localparam int HW = 12;
  localparam int VW = 11;
  localparam int SA = 0;
`ifdef VID_MEASURE_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  typedef struct packed {
    logic [OD-1:0] r;
    logic [OD-1:0] g;
    logic [OD-1:0] b;
    logic          hs;
    logic          vs;
    logic          cep;
    logic          hp;
    logic          vp;
    logic          st;
    logic [HW-1:0] ht;
    logic [VW-1:0] vt;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] ce_div = '0;
  logic          csync_en = 1'b0;
  logic [CD-1:0] R = '0, G = '0, B = '0;
  logic          HSync = 1'b0, VSync = 1'b0;
  logic [OD-1:0] R_out, G_out, B_out;
  logic          HS_out, VS_out, ce_pix, hs_pol, vs_pol, stable;
  logic [HW-1:0] h_total;
  logic [VW-1:0] v_total;

  mist_video_timing #(
    .COLOR_DEPTH(CD), .OUT_DEPTH(OD), .DIV_WIDTH(DW),
    .HCNT_WIDTH(HW), .VCNT_WIDTH(VW), .SYNC_AND(SA)
  ) dut (
    .clk_sys(clk), .reset(reset), .ce_div(ce_div), .csync_en(csync_en),
    .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .HS_out(HS_out), .VS_out(VS_out), .ce_pix(ce_pix),
    .hs_pol(hs_pol), .vs_pol(vs_pol), .stable(stable),
    .h_total(h_total), .v_total(v_total)
  );

  always #5 clk = ~clk;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   have = 0;

  // reference model state
  bit            hq[$], vq[$], lq[$];
  int            h_edges[$], v_edges[$];
  bit            hp, vp, s1hs, s1vs, cep;
  logic [CD-1:0] s1r, s1g, s1b;
  int            div, htot, vtot;
  bit            heq, veq;
  obs_t          cur;

  function automatic logic [OD-1:0] widen(input logic [CD-1:0] c);
    logic [OD-1:0] o;
    for (int i = 0; i < OD; i++) o[OD-1-i] = c[CD-1-(i % CD)];
    return o;
  endfunction

  function automatic void model_step();
    obs_t n;
    bit hsa, vsa, lead, tk, cs, nhp, nvp;
    int idx, p, ones, zeros;
    n = cur;
    if (reset) begin
      hq.delete(); vq.delete(); lq.delete();
      h_edges.delete(); v_edges.delete();
      hq.push_back(HSync); vq.push_back(VSync); lq.push_back(1'b0);
      hp = 0; vp = 0; s1hs = 0; s1vs = 0; cep = 0; div = 0;
      s1r = '0; s1g = '0; s1b = '0;
      htot = 0; vtot = 0; heq = 0; veq = 0;
      n = '0;
      n.hs = 1'b1;
      n.vs = 1'b1;
    end else begin
      hsa = hp ? HSync : !HSync;
      vsa = vp ? VSync : !VSync;
      lead = hsa && !s1hs;
      if (cep) begin
        cs = (SA != 0) ? !(s1hs || s1vs) : !(s1hs ^ s1vs);
        n.r = widen(s1r);
        n.g = widen(s1g);
        n.b = widen(s1b);
        n.hs = csync_en ? cs : !s1hs;
        n.vs = csync_en ? 1'b1 : !s1vs;
      end
      tk = div >= int'(ce_div);
      div = (lead || tk) ? 0 : div + 1;
      cep = tk;
      hq.push_back(HSync); vq.push_back(VSync); lq.push_back(lead);
      idx = hq.size() - 1;
      nhp = hp;
      nvp = vp;
      if (HSync && !hq[idx-1]) begin
        if (h_edges.size() > 0) begin
          p = h_edges[$];
          ones = 0;
          for (int k = p; k < idx; k++) ones += int'(hq[k]);
          zeros = (idx - p) - ones;
          if (ones < zeros) nhp = 1;
          else if (ones > zeros) nhp = 0;
          if (MEAS) begin
            heq = (idx - p) == htot;
            htot = idx - p;
          end
        end
        h_edges.push_back(idx);
      end
      if (VSync && !vq[idx-1]) begin
        if (v_edges.size() > 0) begin
          p = v_edges[$];
          ones = 0;
          zeros = 0;
          for (int k = p; k < idx; k++) begin
            if (lq[k] && vq[k]) ones++;
            if (lq[k] && !vq[k]) zeros++;
          end
          if (ones < zeros) nvp = 1;
          else if (ones > zeros) nvp = 0;
          if (MEAS) begin
            veq = (ones + zeros) == vtot;
            vtot = ones + zeros;
          end
        end
        v_edges.push_back(idx);
      end
      hp = nhp; vp = nvp;
      s1hs = hsa; s1vs = vsa;
      s1r = R; s1g = G; s1b = B;
      n.cep = cep;
      n.hp = hp;
      n.vp = vp;
      n.st = heq && veq;
      n.ht = HW'(htot);
      n.vt = VW'(vtot);
    end
    cur = n;
  endfunction

  task automatic tick_cycle(input bit rst, input int cdv, input bit cs,
                            input bit h, input bit v);
    @(posedge clk);
    #1;
    if (have) sb.push_back(cur);
    reset = rst;
    ce_div = DW'(cdv);
    csync_en = cs;
    HSync = h;
    VSync = v;
    R = CD'($urandom_range(0, (1 << CD) - 1));
    G = CD'($urandom_range(0, (1 << CD) - 1));
    B = CD'($urandom_range(0, (1 << CD) - 1));
    model_step();
    have = 1;
    cyc++;
  endtask

  task automatic run_frames(input int nfr, input int lines, input int len,
                            input int hpw, input bit hhi, input int vpw,
                            input bit vhi, input int cdv, input bit cs,
                            input int rst_at, input int chg_at,
                            input int chg_val, input int long_line);
    int cnt, cd_now, ll;
    bit hact, vact, rst;
    cnt = 0;
    cd_now = cdv;
    for (int f = 0; f < nfr; f++) begin
      for (int l = 0; l < lines; l++) begin
        ll = (f == nfr - 1 && l == long_line) ? len + 1 : len;
        for (int c = 0; c < ll; c++) begin
          if (cnt == chg_at) cd_now = chg_val;
          rst = (cnt >= rst_at) && (cnt < rst_at + 3);
          hact = c < hpw;
          vact = l < vpw;
          tick_cycle(rst, cd_now, cs, hhi ? hact : !hact, vhi ? vact : !vact);
          cnt++;
        end
      end
    end
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a.r = R_out; a.g = G_out; a.b = B_out;
        a.hs = HS_out; a.vs = VS_out; a.cep = ce_pix;
        a.hp = hs_pol; a.vp = vs_pol; a.st = stable;
        a.ht = h_total; a.vt = v_total;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, a, e);
        end
      end
    end
  end

  initial begin : stim
    int len, lines, hpw, rst_at, chg_at;
    repeat (4) tick_cycle(1'b1, 3, 1'b0, 1'b0, 1'b1);
    // 800-clk lines, 96 high / 704 low hsync, active-low vsync
    run_frames(3, 6, 800, 96, 1'b1, 2, 1'b0, 3, 1'b0, -10, -1, 0, -1);
    // composite sync, short lines
    run_frames(2, 10, 64, 8, 1'b1, 2, 1'b0, 1, 1'b1, -10, -1, 0, -1);
    // divider 7 -> 1 mid-line
    run_frames(2, 10, 80, 10, 1'b0, 3, 1'b1, 7, 1'b0, -10, 205, 1, -1);
    // one longer line in the last frame
    run_frames(4, 10, 50, 6, 1'b1, 2, 1'b1, 2, 1'b0, -10, -1, 0, 4);
    // equal high/low time keeps the previous polarity
    run_frames(2, 8, 40, 20, 1'b0, 2, 1'b0, 0, 1'b0, -10, -1, 0, -1);
    for (int s = 0; s < 14; s++) begin
      len = $urandom_range(20, 60);
      lines = $urandom_range(6, 12);
      hpw = $urandom_range(2, len / 3);
      rst_at = ($urandom_range(0, 2) == 0) ?
               $urandom_range(0, 2 * len * lines - 1) : -10;
      chg_at = ($urandom_range(0, 1) == 0) ?
               $urandom_range(0, 2 * len * lines - 1) : -1;
      run_frames(2, lines, len, hpw, 1'($urandom_range(0, 1)),
                 $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                 rst_at, chg_at, $urandom_range(0, 7),
                 $urandom_range(0, 1) == 0 ? $urandom_range(0, lines - 1) : -1);
    end
    @(posedge clk);
    #1;
    sb.push_back(cur);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
